// File: rtl/dcm_seq_pkg.sv
// Shared types and sizing helpers for the DCM lock sequencer.
package dcm_seq_pkg;

    localparam int unsigned RETRY_W = 3;

    typedef enum logic [4:0] {
        HOLD      = 5'b00001,
        WAIT_LOCK = 5'b00010,
        STABLE    = 5'b00100,
        RUN       = 5'b01000,
        FAULT     = 5'b10000
    } state_t;

    // Counter width covering the largest cycle parameter; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/dcm_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer and its DCM/VGA surroundings.
interface dcm_lock_sequencer_if;
    import dcm_seq_pkg::*;

    logic               LOCKED_IN;
    logic               RESTART_IN;
    logic               DCM_RST_OUT;
    logic               SYS_RST_OUT;
    logic               READY_OUT;
    logic               FAULT_OUT;
    logic               LOCK_LOST_OUT;
    logic [RETRY_W-1:0] RETRY_CNT_OUT;

    modport master (
        output LOCKED_IN, RESTART_IN,
        input  DCM_RST_OUT, SYS_RST_OUT, READY_OUT, FAULT_OUT, LOCK_LOST_OUT, RETRY_CNT_OUT
    );

    modport slave (
        input  LOCKED_IN, RESTART_IN,
        output DCM_RST_OUT, SYS_RST_OUT, READY_OUT, FAULT_OUT, LOCK_LOST_OUT, RETRY_CNT_OUT
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dcm_lock_sequencer.sv
// Sequences DCM reset, lock wait/qualification and VGA system-reset release,
// retrying on failure and latching a fault after too many failed attempts.
module dcm_lock_sequencer
    import dcm_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 3,
    parameter int unsigned LOCK_TIMEOUT    = 4096,
    parameter int unsigned STABLE_CYCLES   = 16,
    parameter int unsigned MAX_RETRIES     = 4
) (
    input  logic                 CLKIN_IN,
    input  logic                 RST_N_IN,
    dcm_lock_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W =
        cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, MAX_RETRIES);
    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               lost_q, lost_d;
    logic               fail;
    logic               lk;
    logic               dcm_rst_q, sys_rst_q, ready_q, fault_q;

    sync_2ff u_lock_sync (
        .clk   (CLKIN_IN),
        .rst_n (RST_N_IN),
        .d     (bus.LOCKED_IN),
        .q     (lk)
    );

    // Next-state logic; restart outranks every other transition.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        retry_d   = retry_q;
        lost_d    = lost_q;
        fail      = 1'b0;
        retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);

        if (bus.RESTART_IN) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = '0;
            lost_d  = 1'b0;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lk)                         state_d = STABLE;
                    else if (cnt_q == TIMEOUT_LAST) fail    = 1'b1;
                end
                STABLE: begin
                    if (!lk) begin
                        fail = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q;
                    if (!lk) begin
                        state_d = HOLD;
                        lost_d  = 1'b1;
                    end
                end
                FAULT: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = HOLD;
                end
            endcase

            if (fail) begin
                retry_d = retry_inc;
                state_d = (retry_inc == RETRY_LIMIT) ? FAULT : HOLD;
            end

            // Every state entry restarts the shared counter.
            if (state_d != state_q) cnt_d = '0;
        end
    end

    // State, counters and outputs, all decoded from the next state so they stay registered.
    always_ff @(posedge CLKIN_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            retry_q   <= '0;
            lost_q    <= 1'b0;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            dcm_rst_q <= (state_d == HOLD) || (state_d == FAULT);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
            fault_q   <= (state_d == FAULT);
        end
    end

    assign bus.DCM_RST_OUT   = dcm_rst_q;
    assign bus.SYS_RST_OUT   = sys_rst_q;
    assign bus.READY_OUT     = ready_q;
    assign bus.FAULT_OUT     = fault_q;
    assign bus.LOCK_LOST_OUT = lost_q;
    assign bus.RETRY_CNT_OUT = retry_q;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Randomized scoreboard bench for dcm_lock_sequencer against an attempt-based reference model.
module tb_dcm_lock_sequencer;

    localparam int H = 3;
    localparam int T = 64;
    localparam int S = 16;
    localparam int R = 4;

    typedef struct packed {
        logic       dcm;
        logic       sys;
        logic       ready;
        logic       fault;
        logic       lost;
        logic [2:0] retry;
    } obs_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    dcm_lock_sequencer_if bus();

    dcm_lock_sequencer #(
        .RST_HOLD_CYCLES (H),
        .LOCK_TIMEOUT    (T),
        .STABLE_CYCLES   (S),
        .MAX_RETRIES     (R)
    ) dut (
        .CLKIN_IN (clk),
        .RST_N_IN (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: an attempt is HOLD for H edges, then up to T edges of waiting,
    // then S consecutive locked edges; lk is LOCKED_IN as sampled two edges earlier.
    int age;
    int lock_age;
    int retries;
    bit running;
    bit in_fault;
    bit lost;
    bit s1;
    bit s2;

    function automatic void new_attempt();
        age      = 0;
        lock_age = -1;
        running  = 1'b0;
    endfunction

    function automatic void model_reset();
        new_attempt();
        retries  = 0;
        in_fault = 1'b0;
        lost     = 1'b0;
        s1       = 1'b0;
        s2       = 1'b0;
    endfunction

    function automatic void attempt_failed();
        if (retries < 7) retries++;
        if (retries == R) begin
            in_fault = 1'b1;
            running  = 1'b0;
        end else begin
            new_attempt();
        end
    endfunction

    function automatic void model_step(input bit locked, input bit restart);
        bit lk;
        lk = s2;
        s2 = s1;
        s1 = locked;
        if (restart) begin
            new_attempt();
            retries  = 0;
            in_fault = 1'b0;
            lost     = 1'b0;
        end else if (in_fault) begin
            // only restart or reset leaves the fault
        end else if (running) begin
            if (!lk) begin
                lost = 1'b1;
                new_attempt();
            end
        end else if (age < H) begin
            age++;
        end else if (lock_age < 0) begin
            if (lk) begin
                age++;
                lock_age = age;
            end else if (age - H == T - 1) begin
                attempt_failed();
            end else begin
                age++;
            end
        end else begin
            if (!lk) begin
                attempt_failed();
            end else if (age - lock_age == S - 1) begin
                running = 1'b1;
                retries = 0;
            end else begin
                age++;
            end
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.dcm   = in_fault || (!running && age < H);
        o.sys   = !running;
        o.ready = running;
        o.fault = in_fault;
        o.lost  = lost;
        o.retry = 3'(retries);
        return o;
    endfunction

    // Predictor: one expectation per clock edge; reset is only asserted while clk is low.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (clk) begin
                if (!rst_n) model_reset();
                else        model_step(bus.LOCKED_IN, bus.RESTART_IN);
                exp_q.push_back(model_obs());
            end else begin
                model_reset();
                exp_q.delete();
            end
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation on each falling edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{bus.DCM_RST_OUT, bus.SYS_RST_OUT, bus.READY_OUT, bus.FAULT_OUT,
                      bus.LOCK_LOST_OUT, bus.RETRY_CNT_OUT};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got dcm=%b sys=%b rdy=%b flt=%b lost=%b retry=%0d, required dcm=%b sys=%b rdy=%b flt=%b lost=%b retry=%0d",
                             $time, a.dcm, a.sys, a.ready, a.fault, a.lost, a.retry,
                             e.dcm, e.sys, e.ready, e.fault, e.lost, e.retry);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_restart();
        bus.RESTART_IN = 1'b1;
        @(negedge clk);
        bus.RESTART_IN = 1'b0;
    endtask

    // Immediate check that reset values appear without any clock edge.
    task automatic check_async_reset(input string name);
        obs_t a;
        obs_t e;
        e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        a = '{bus.DCM_RST_OUT, bus.SYS_RST_OUT, bus.READY_OUT, bus.FAULT_OUT,
              bus.LOCK_LOST_OUT, bus.RETRY_CNT_OUT};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, a, e);
        end
    endtask

    initial begin
        bus.LOCKED_IN  = 1'b0;
        bus.RESTART_IN = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_async_reset("power_on_reset");
        cycles(3);
        rst_n = 1'b1;

        // Cold start, lock arrives at cycle 10
        cycles(10);
        bus.LOCKED_IN = 1'b1;
        cycles(40);

        // Lock loss in RUN, then re-lock
        bus.LOCKED_IN = 1'b0;
        cycles(2);
        bus.LOCKED_IN = 1'b1;
        cycles(40);

        // Restart clears the sticky lock-lost flag
        pulse_restart();
        cycles(40);

        // One-cycle glitch while qualifying lock (stable counter at 8)
        pulse_restart();
        cycles(9);
        bus.LOCKED_IN = 1'b0;
        cycles(1);
        bus.LOCKED_IN = 1'b1;
        cycles(40);

        // Repeated timeouts into FAULT
        bus.LOCKED_IN = 1'b0;
        pulse_restart();
        cycles(4 * (H + T) + 10);

        // Restart out of FAULT with lock present
        bus.LOCKED_IN = 1'b1;
        pulse_restart();
        cycles(40);

        // Asynchronous reset in the middle of WAIT_LOCK
        bus.LOCKED_IN = 1'b0;
        pulse_restart();
        cycles(10);
        #2 rst_n = 1'b0;
        #1 check_async_reset("mid_wait_reset");
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Restart landing on the same edge as a timeout
        pulse_restart();
        cycles(H + T - 1);
        pulse_restart();
        cycles(10);
        bus.LOCKED_IN = 1'b1;
        cycles(30);

        // Randomized lock activity with occasional restarts
        for (int i = 0; i < 30; i++) begin
            bus.LOCKED_IN  = ($urandom_range(0, 3) != 0);
            bus.RESTART_IN = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            bus.RESTART_IN = 1'b0;
            cycles($urandom_range(1, 40));
        end
        cycles(2);

        checks++;
        if (checks < 500) begin
            errors++;
            $display("FAIL check_count: got %0d, required at least 500", checks);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
